bram_pingpong_srp: RTL and testbench
====================================

# bram_pingpong_srp

Parametrised two-bank (ping-pong) block-RAM sample buffer for the Shapiro-Rudin-Park time synchroniser. A streaming writer fills one bank sequentially while the correlator randomly reads the other, previously completed bank. Banks swap automatically when a frame is complete and the reader has released its bank. The writer back-pressures, and dropped samples are counted, so no frame is ever overwritten while it is being read.

## Interface
Parameters:
- DATA_W, 32, sample word width
- DEPTH, 2096, words per bank (frame length); must be ≥ 2
- ADDR_W, 12, address width; must satisfy 2^ADDR_W ≥ DEPTH
- OUT_REG, 0, 1 adds an output pipeline register on the read path

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  sample present on wr_data
- wr_data  in  DATA_W  sample
- wr_ready  out  1  writer may accept a sample this cycle
- wr_level  out  ADDR_W+1  words written into the current write bank
- frame_ready  out  1  one-cycle pulse on every bank swap
- rd_bank_valid  out  1  reader owns a complete bank
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  word address within the read bank
- rd_release  in  1  one-cycle pulse: reader is finished with its bank
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data valid
- ovf_cnt  out  16  samples dropped while wr_ready=0, saturating

## Operation
- Storage: 2×DEPTH words, inferred as block RAM. Bank selects are wr_sel and rd_sel. Memory contents are not cleared by reset.
- Writer FSM states:
  - FILL: wr_ready=1.
  - WAIT: frame complete, no free bank; wr_ready=0.
- Write accept: wr_valid & wr_ready writes mem[wr_sel][wr_level], then wr_level++.
- Swap condition: frame complete (accept with wr_level=DEPTH-1, or state WAIT) and (rd_bank_valid=0 or rd_release=1 this cycle).
- Swap actions, all in the same edge:
  - rd_sel←wr_sel, wr_sel←~wr_sel, wr_level←0
  - rd_bank_valid←1, frame_ready pulse, state→FILL
- Frame complete without a free bank: state→WAIT, wr_level holds DEPTH.
- rd_release with rd_bank_valid=1 and no swap: rd_bank_valid←0.
- rd_release with rd_bank_valid=0: ignored.
- Read: rd_en & rd_bank_valid reads mem[rd_sel][rd_addr]. The bank is latched at issue, so a read issued in the rd_release or swap cycle returns the old bank's data.
- rd_en while rd_bank_valid=0: no read, rd_valid stays 0.
- rd_addr ≥ DEPTH: rd_valid asserted, rd_data=0.
- Overflow: wr_valid & ~wr_ready increments ovf_cnt, saturating at 16'hFFFF. The dropped sample is discarded.
- No write/read collision is possible, because writer and reader always use different banks.

## Timing
- Reset values:
  - wr_ready=0 while rst is high, 1 (FILL) from the first edge after release
  - wr_level=0, frame_ready=0, rd_bank_valid=0, rd_valid=0, rd_data=0, ovf_cnt=0, wr_sel=0, rd_sel=1
- Reset mid-frame discards the partial frame and reader ownership immediately, asynchronously.
- Read latency: rd_en at edge N → rd_valid/rd_data at edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1). Back-to-back reads sustain one per cycle.
- Swap: the edge that accepts the last word, or the rd_release edge in WAIT, also sets rd_bank_valid and pulses frame_ready for exactly one cycle. The new bank is readable from the next cycle.
- wr_ready is combinational from state: it drops in the cycle after a last-word accept that does not swap, and rises in the cycle after a releasing swap.
- Simultaneous last write and rd_release: swap occurs, WAIT is never entered, and rd_bank_valid stays 1 continuously.
- Throughput: with the reader releasing before each frame completes, one sample per cycle with no stall.

## Test plan
- Reset, DEPTH=8: write 0..7 continuously → frame_ready pulses on the 8th accept, rd_bank_valid=1; reads of addr 0..7 return 0..7 with latency 1 (OUT_REG=0) and latency 2 (OUT_REG=1).
- Fill a second frame 8..15 without release → wr_ready=0 after the 16th accept, WAIT entered; 5 more wr_valid cycles → ovf_cnt=5; rd_release → swap, reads return 8..15, wr_ready=1, wr_level=0.
- Last write and rd_release in the same cycle → single frame_ready pulse, rd_bank_valid never drops, wr_ready never drops.
- rd_en in the rd_release/swap cycle → returns the old bank's data; rd_en with rd_bank_valid=0 → no rd_valid; rd_addr=8 → rd_valid=1, rd_data=0.
- Assert rst after 3 accepts with a bank owned → all outputs at reset values; the next frame starts at wr_level=0 in bank 0.
- Force 70000 drops → ovf_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/bram_pingpong_srp_if.sv
// bram_pingpong_srp_if: writer/reader bus of the ping-pong sample buffer
interface bram_pingpong_srp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [ADDR_W:0]   wr_level;
  logic              frame_ready;
  logic              rd_bank_valid;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_release;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [15:0]       ovf_cnt;
  modport master (
    output wr_valid, wr_data, rd_en, rd_addr, rd_release,
    input  wr_ready, wr_level, frame_ready, rd_bank_valid, rd_data, rd_valid, ovf_cnt
  );
  modport slave (
    input  wr_valid, wr_data, rd_en, rd_addr, rd_release,
    output wr_ready, wr_level, frame_ready, rd_bank_valid, rd_data, rd_valid, ovf_cnt
  );
endinterface

// File: rtl/bram_pingpong_srp.sv
// bram_pingpong_srp: two-bank block-RAM sample buffer, writer fills one bank while the reader owns the other
module bram_pingpong_srp #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 2096,
  parameter int ADDR_W  = 12,
  parameter int OUT_REG = 0
) (
  input logic clk,
  input logic rst,
  bram_pingpong_srp_if.slave bus
);
  localparam int IW = ADDR_W + 1;
  localparam int MW = $clog2(2 * DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  localparam logic [IW-1:0] FULL = IW'(DEPTH);
  typedef enum logic [1:0] {IDLE, FILL, WAIT} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [2*DEPTH];
  logic wr_sel, rd_sel, rd_bank_valid, frame_ready, ready;
  logic accept, complete, swap, rd_go, rd_hit, vld_q, hit_q;
  logic [IW-1:0] wr_level, wr_idx, rd_idx, rd_ext;
  logic [DATA_W-1:0] ram_q, rd_mux;
  logic [15:0] ovf;
  always_comb begin
    ready    = state == FILL;
    accept   = bus.wr_valid & ready;
    complete = (accept & (wr_level == LAST)) | (state == WAIT);
    swap     = complete & (~rd_bank_valid | bus.rd_release);
    rd_ext   = {1'b0, bus.rd_addr};
    rd_go    = bus.rd_en & rd_bank_valid;
    rd_hit   = rd_go & (rd_ext < FULL);
    wr_idx   = wr_sel ? FULL + wr_level : wr_level;
    rd_idx   = rd_sel ? FULL + rd_ext : rd_ext;
    rd_mux   = hit_q ? ram_q : '0;
  end
  // Storage is left unreset so it maps onto block RAM; out-of-range reads skip the array.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_idx[MW-1:0]] <= bus.wr_data;
    if (rd_hit) ram_q <= mem[rd_idx[MW-1:0]];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wr_sel        <= 1'b0;
      rd_sel        <= 1'b1;
      wr_level      <= '0;
      rd_bank_valid <= 1'b0;
      frame_ready   <= 1'b0;
      ovf           <= '0;
      vld_q         <= 1'b0;
      hit_q         <= 1'b0;
    end else begin
      frame_ready <= swap;
      vld_q       <= rd_go;
      hit_q       <= rd_hit;
      if (bus.wr_valid & ~ready & ~&ovf) ovf <= ovf + 16'd1;
      if (swap) begin
        rd_sel        <= wr_sel;
        wr_sel        <= ~wr_sel;
        wr_level      <= '0;
        rd_bank_valid <= 1'b1;
        state         <= FILL;
      end else begin
        // A non-swapping last accept leaves wr_level parked at DEPTH while waiting.
        if (accept) wr_level <= wr_level + 1'b1;
        if (complete) state <= WAIT;
        else if (state == IDLE) state <= FILL;
        if (bus.rd_release) rd_bank_valid <= 1'b0;
      end
    end
  end
  generate
    if (OUT_REG != 0) begin : g_out
      logic [DATA_W-1:0] data_q;
      logic              valid_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          data_q  <= rd_mux;
          valid_q <= vld_q;
        end
      end
      assign bus.rd_data  = data_q;
      assign bus.rd_valid = valid_q;
    end else begin : g_dir
      assign bus.rd_data  = rd_mux;
      assign bus.rd_valid = vld_q;
    end
  endgenerate
  assign bus.wr_ready      = ready;
  assign bus.wr_level      = wr_level;
  assign bus.frame_ready   = frame_ready;
  assign bus.rd_bank_valid = rd_bank_valid;
  assign bus.ovf_cnt       = ovf;
endmodule

// File: tb/tb_bram_pingpong_srp.sv
// tb_bram_pingpong_srp: scoreboard bench for both read-latency variants against a frame-level model
module tb_bram_pingpong_srp;
  localparam int DW = 32;
  localparam int D  = 8;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wv = 1'b0, re = 1'b0, rr = 1'b0;
  logic [DW-1:0] wd = '0;
  logic [AW-1:0] ra = '0;
  always #5 clk = ~clk;
  bram_pingpong_srp_if #(.DATA_W(DW), .ADDR_W(AW)) b0 ();
  bram_pingpong_srp_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();
  assign b0.wr_valid = wv;
  assign b0.wr_data = wd;
  assign b0.rd_en = re;
  assign b0.rd_addr = ra;
  assign b0.rd_release = rr;
  assign b1.wr_valid = wv;
  assign b1.wr_data = wd;
  assign b1.rd_en = re;
  assign b1.rd_addr = ra;
  assign b1.rd_release = rr;
  bram_pingpong_srp #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW), .OUT_REG(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  bram_pingpong_srp #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW), .OUT_REG(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  typedef struct {logic [DW-1:0] d; int c;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int errs = 0;
  int checks = 0;
  int cyc = 0;
  bit m_started, m_owned, m_pulse;
  logic [DW-1:0] m_frame[$];
  logic [DW-1:0] m_bank[D];
  int m_ovf;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic bit m_ready();
    return m_started && m_frame.size() < D;
  endfunction
  task automatic model_reset();
    m_started = 0;
    m_owned = 0;
    m_pulse = 0;
    m_frame.delete();
    m_ovf = 0;
    q0.delete();
    q1.delete();
  endtask
  task automatic model_step();
    bit rdy;
    logic [DW-1:0] e;
    rdy = m_ready();
    if (re && m_owned) begin
      e = (ra < D) ? m_bank[ra] : '0;
      q0.push_back('{e, cyc});
      q1.push_back('{e, cyc});
    end
    if (wv && !rdy && m_ovf < 65535) m_ovf++;
    if (wv && rdy) m_frame.push_back(wd);
    m_pulse = 0;
    if (m_frame.size() == D && (!m_owned || rr)) begin
      for (int i = 0; i < D; i++) m_bank[i] = m_frame[i];
      m_frame.delete();
      m_owned = 1;
      m_pulse = 1;
    end else if (rr) m_owned = 0;
    m_started = 1;
  endtask
  task automatic check_outs();
    chk("wr_ready0", b0.wr_ready, m_ready());
    chk("wr_ready1", b1.wr_ready, m_ready());
    chk("wr_level0", b0.wr_level, m_frame.size());
    chk("wr_level1", b1.wr_level, m_frame.size());
    chk("frame_ready0", b0.frame_ready, m_pulse);
    chk("frame_ready1", b1.frame_ready, m_pulse);
    chk("rd_bank_valid0", b0.rd_bank_valid, m_owned);
    chk("rd_bank_valid1", b1.rd_bank_valid, m_owned);
    chk("ovf_cnt0", b0.ovf_cnt, m_ovf);
    chk("ovf_cnt1", b1.ovf_cnt, m_ovf);
  endtask
  task automatic check_rd_idle();
    chk("rst_rd_valid0", b0.rd_valid, 0);
    chk("rst_rd_valid1", b1.rd_valid, 0);
    chk("rst_rd_data0", b0.rd_data, 0);
    chk("rst_rd_data1", b1.rd_data, 0);
  endtask
  task automatic tick(input logic v, input logic [DW-1:0] d, input logic e, input logic [AW-1:0] a, input logic r);
    wv = v;
    wd = d;
    re = e;
    ra = a;
    rr = r;
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    check_outs();
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (!rst && b0.rd_valid) begin
      if (q0.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL rd_unexpected0: got rd_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        x = q0.pop_front();
        chk("rd_data0", b0.rd_data, x.d);
        chk("rd_latency0", cyc - x.c, 1);
      end
    end
  end
  always @(negedge clk) begin
    exp_t x;
    if (!rst && b1.rd_valid) begin
      if (q1.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL rd_unexpected1: got rd_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        x = q1.pop_front();
        chk("rd_data1", b1.rd_data, x.d);
        chk("rd_latency1", cyc - x.c, 2);
      end
    end
  end
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_outs();
    check_rd_idle();
    rst = 1'b0;
    tick(0, 0, 0, 0, 0);
    for (int i = 0; i < D; i++) tick(1, i, 0, 0, 0);
    chk("first_frame_ready", b0.frame_ready, 1);
    chk("first_bank_valid", b0.rd_bank_valid, 1);
    for (int i = 0; i < D; i++) tick(1, D + i, 1, AW'(i), 0);
    chk("wait_wr_ready", b0.wr_ready, 0);
    repeat (5) tick(1, 32'hdead, 0, 0, 0);
    chk("ovf_after_5", b0.ovf_cnt, 5);
    tick(0, 0, 1, 0, 1);
    chk("swap_wr_ready", b0.wr_ready, 1);
    chk("swap_wr_level", b0.wr_level, 0);
    for (int i = 0; i < D; i++) tick(0, 0, 1, AW'(i), 0);
    for (int i = 0; i < D - 1; i++) tick(1, 16 + i, 0, 0, 0);
    tick(1, 23, 0, 0, 1);
    chk("same_cycle_pulse", b0.frame_ready, 1);
    chk("same_cycle_bank", b0.rd_bank_valid, 1);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 1, 2, 0);
    for (int i = 0; i < D; i++) tick(1, 24 + i, 0, 0, 0);
    tick(0, 0, 1, 8, 0);
    tick(0, 0, 1, 3, 0);
    for (int i = 0; i < 3; i++) tick(1, 40 + i, 0, 0, 0);
    repeat (2) tick(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1 model_reset();
    check_outs();
    check_rd_idle();
    tick(0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(0, 0, 0, 0, 0);
    for (int i = 0; i < D; i++) tick(1, 50 + i, 0, 0, 0);
    for (int i = 0; i < D; i++) tick(0, 0, 1, AW'(i), 0);
    repeat (600) tick($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 2) == 0,
                      AW'($urandom_range(0, 9)), $urandom_range(0, 9) == 0);
    repeat (65560) tick(1, $urandom, 0, 0, 0);
    chk("ovf_saturated", b0.ovf_cnt, 16'hFFFF);
    repeat (4) tick(0, 0, 0, 0, 0);
    chk("pending_reads0", q0.size(), 0);
    chk("pending_reads1", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
